// File: rtl/dma_pkt_pkg.sv
// dma_pkt_pkg: packet-level definitions shared by both halves of the DMA link
// (host-to-device packet_receiver and device-to-host packet sender).
//   host_pkt_t          : type field (header bits [7:6]) of host-to-device packets
//   READ_REQ/WRITE/...  : type codes of device-to-host packets
//   TILE_WORDS/BYTES    : geometry of a read-response tile
package dma_pkt_pkg;

    typedef enum logic [1:0] {
        READ_RESP  = 2'd0,
        PROG_WRITE = 2'd1,
        START      = 2'd2,
        RSVD       = 2'd3
    } host_pkt_t;

    localparam logic [1:0] READ_REQ = 2'd0;
    localparam logic [1:0] WRITE    = 2'd1;
    localparam logic [1:0] END_PROG = 2'd2;

    localparam int unsigned TILE_WORDS = 18;
    localparam int unsigned TILE_BYTES = 36;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all ones instead of wrapping.
//   clk   : clock
//   reset : synchronous, active-low clear
//   inc   : count one event this cycle
//   count : current count
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/packet_receiver.sv
// packet_receiver: reassembles host packets from a UART byte stream and
// delivers read-response tiles, program-memory writes and start pulses.
// The link has no backpressure, so malformed, stalled or undeliverable
// packets are only counted.
//   clk, reset                 : clock, synchronous active-low reset
//   rx_valid, rx_data          : one received byte per strobe
//   dma_recv_read_queue_full   : read-return queue cannot take a tile
//   dma_recv_read_queue_we/data: tile write strobe, first byte in the MSBs
//   prog_we, prog_addr, prog_data : program-memory write
//   start_program              : start pulse
//   bad_header_count, timeout_count, drop_count : saturating error counters
module packet_receiver
    import dma_pkt_pkg::*;
#(
    parameter int unsigned TILE_BYTES     = dma_pkt_pkg::TILE_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    dma_recv_read_queue_full,
    output logic                    dma_recv_read_queue_we,
    output logic [8*TILE_BYTES-1:0] dma_recv_read_queue_data,
    output logic                    prog_we,
    output logic [15:0]             prog_addr,
    output logic [15:0]             prog_data,
    output logic                    start_program,
    output logic [CNT_W-1:0]        bad_header_count,
    output logic [CNT_W-1:0]        timeout_count,
    output logic [CNT_W-1:0]        drop_count
);

    localparam int unsigned TILE_W    = 8 * TILE_BYTES;
    localparam int unsigned CNT_BITS  = $clog2(TILE_BYTES + 1);
    localparam int unsigned IDLE_BITS = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TILE = 2'd1;
    localparam logic [1:0] S_PROG = 2'd2;

    logic [1:0]           state;
    logic [CNT_BITS-1:0]  cnt;
    logic [IDLE_BITS-1:0] idle_cnt;
    logic [TILE_W-1:0]    tile_sr;
    logic [23:0]          prog_sr;
    host_pkt_t            hdr_type;
    logic                 timeout;
    logic                 tile_last;
    logic                 prog_last;
    logic                 bad_inc;
    logic                 drop_inc;

    // A timeout takes priority over a byte arriving in the same cycle:
    // that byte is dropped rather than parsed.
    always_comb begin
        hdr_type  = host_pkt_t'(rx_data[7:6]);
        timeout   = (state != S_IDLE) && (idle_cnt == IDLE_BITS'(TIMEOUT_CYCLES));
        tile_last = (state == S_TILE) && !timeout && rx_valid
                    && (cnt == CNT_BITS'(TILE_BYTES - 1));
        prog_last = (state == S_PROG) && !timeout && rx_valid
                    && (cnt == CNT_BITS'(3));
        bad_inc   = (state == S_IDLE) && rx_valid && (hdr_type == RSVD);
        drop_inc  = tile_last && dma_recv_read_queue_full;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state                  <= S_IDLE;
            cnt                    <= '0;
            idle_cnt               <= '0;
            tile_sr                <= '0;
            prog_sr                <= '0;
            prog_addr              <= '0;
            prog_data              <= '0;
            dma_recv_read_queue_we <= 1'b0;
            prog_we                <= 1'b0;
            start_program          <= 1'b0;
        end else begin
            dma_recv_read_queue_we <= 1'b0;
            prog_we                <= 1'b0;
            start_program          <= 1'b0;
            if (state == S_IDLE) begin
                idle_cnt <= '0;
                if (rx_valid) begin
                    cnt <= '0;
                    case (hdr_type)
                        READ_RESP:  state         <= S_TILE;
                        PROG_WRITE: state         <= S_PROG;
                        START:      start_program <= 1'b1;
                        default:    ;
                    endcase
                end
            end else if (timeout) begin
                state    <= S_IDLE;
                idle_cnt <= '0;
            end else if (rx_valid) begin
                idle_cnt <= '0;
                cnt      <= cnt + 1'b1;
                if (state == S_TILE) begin
                    tile_sr <= {tile_sr[TILE_W-9:0], rx_data};
                    if (tile_last) begin
                        state                  <= S_IDLE;
                        dma_recv_read_queue_we <= !dma_recv_read_queue_full;
                    end
                end else begin
                    // Program bytes are staged so a partial packet never
                    // disturbs the address/data last written.
                    prog_sr <= {prog_sr[15:0], rx_data};
                    if (prog_last) begin
                        state     <= S_IDLE;
                        prog_addr <= prog_sr[23:8];
                        prog_data <= {prog_sr[7:0], rx_data};
                        prog_we   <= 1'b1;
                    end
                end
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    assign dma_recv_read_queue_data = tile_sr;

    sat_counter #(.WIDTH(CNT_W)) u_bad_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bad_inc),
        .count (bad_header_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (timeout),
        .count (timeout_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_inc),
        .count (drop_count)
    );

endmodule

// File: doc/packet_receiver.md
Name: packet_receiver

Overview:
- Host-to-device half of the DMA link; mirrors the device-to-host packet sender.
- Consumes one UART byte at a time and reassembles host packets. Each packet is one header byte plus a payload.
- Delivers three packet kinds to the core:
  - read-response tiles, into the DMA read-return queue;
  - program-memory writes;
  - a start-program pulse.
- Unknown packets, stalled packets and dropped packets are counted, never stalled: the link has no backpressure.

Parameters:
- TILE_BYTES, 36, payload bytes of a read response (18 x 16-bit words).
- TIMEOUT_CYCLES, 100000, idle cycles mid-packet before the frame is abandoned.
- CNT_W, 8, width of the error/drop counters (saturating).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- dma_recv_read_queue_full  in  1  read-return queue cannot accept a write
- dma_recv_read_queue_we  out  1  one-cycle write strobe
- dma_recv_read_queue_data  out  18*16  tile; first received byte in bits [287:280]
- prog_we  out  1  one-cycle program-memory write strobe
- prog_addr  out  16  program-memory address
- prog_data  out  16  instruction word
- start_program  out  1  one-cycle pulse
- bad_header_count  out  CNT_W  packets with reserved type
- timeout_count  out  CNT_W  frames abandoned by timeout
- drop_count  out  CNT_W  tiles discarded because the queue was full

Behaviour:
- Header byte format: type = rx_data[7:6]; bits [5:0] are ignored (reserved).
  - type 0: READ_RESP, 36 payload bytes.
  - type 1: PROG_WRITE, 4 payload bytes: addr hi, addr lo, data hi, data lo.
  - type 2: START, 0 payload bytes.
  - type 3: reserved.
- Multi-byte fields are big-endian. Bytes are consumed only on cycles with rx_valid=1.
- States: IDLE, RECV_TILE, RECV_PROG. A byte counter `cnt` is cleared on every header.
- IDLE, on rx_valid:
  - type 0: go to RECV_TILE.
  - type 1: go to RECV_PROG.
  - type 2: start_program=1 the next cycle; stay in IDLE.
  - type 3: bad_header_count +1; stay in IDLE; the byte is discarded.
- RECV_TILE:
  - Each byte shifts into a 288-bit shift register (left shift by 8, new byte in the LSBs); cnt +1.
  - On byte number TILE_BYTES, return to IDLE. The cycle after that byte:
    - if dma_recv_read_queue_full=0: we=1 and data = the assembled tile;
    - else: no write and drop_count +1.
  - Queue full is sampled in the cycle the last byte arrives.
- RECV_PROG:
  - Bytes 1-2 load prog_addr; bytes 3-4 load prog_data.
  - After byte 4: prog_we=1 the next cycle; return to IDLE.
  - prog_addr and prog_data hold until the next PROG_WRITE.
- Latency: every output strobe comes 1 cycle after the rx_valid of the completing byte. Strobes are single-cycle, registered outputs.
- Timeout:
  - In RECV_TILE or RECV_PROG, an idle counter counts cycles without rx_valid and clears on each byte.
  - Reaching TIMEOUT_CYCLES: return to IDLE, timeout_count +1, partial data discarded, no strobe.
  - A byte arriving in the same cycle as the timeout is consumed as a header in IDLE on a later byte only: the timeout wins and that byte is dropped.
- Counters saturate at all ones and never wrap.
- Back-to-back bytes are legal on every cycle; the block never stalls.
- Reset (reset=0, sampled at posedge):
  - state IDLE, cnt 0, idle counter 0;
  - all strobes 0; prog_addr, prog_data, tile register and all counters 0.
  - Reset mid-packet discards the partial packet; the first byte after reset is treated as a header.

Decomposition:
- Shared package `dma_pkt_pkg`:
  - enum `host_pkt_t` {READ_RESP=0, PROG_WRITE=1, START=2, RSVD=3};
  - device-to-host type constants (READ_REQ=0, WRITE=1, END_PROG=2);
  - constants TILE_WORDS=18, TILE_BYTES=36.
- The packet sender is updated to use the same package.
- One sub-module, `sat_counter` (parameterised width, inc input, sync active-low clear), instantiated three times.

Test Plan:
- Tile: header 0x00, then bytes 0x01..0x24, queue not full -> one cycle of we=1 after the last byte; data[287:280]=0x01, data[7:0]=0x24; no other strobes.
- Program write: bytes 0x40,0x12,0x34,0xAB,0xCD -> prog_we=1 for one cycle with prog_addr=0x1234, prog_data=0xABCD.
- Start plus reserved header: 0x80 then 0xC5 -> start_program pulse; bad_header_count=1.
  - A following 0x40,0,1,0,2 still yields prog_addr=1, prog_data=2, proving resync.
- Full queue: complete a tile with queue_full=1 on the last byte -> no we; drop_count=1.
  - The next tile with full=0 is written correctly.
- Timeout: header 0x00 plus 10 bytes, then an idle gap of TIMEOUT_CYCLES (set to 50) -> timeout_count=1, no we.
  - A fresh 0x80 then gives start_program.
- Reset mid-tile: assert reset after 20 payload bytes -> all outputs 0.
  - Then a full tile with bytes 0xFF is delivered intact, with no residue from the earlier bytes.
